// File: rtl/fifo_array_drain.sv
// Read-side drain controller for the systolic output FIFO array: pops one word per
// column per row in row-major order and streams it out with a linear address.
module fifo_array_drain #(
  parameter int data_size  = 8,
  parameter int array_size = 9,
  parameter int col_bits   = 4,
  parameter int row_bits   = 8,
  parameter int addr_width = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [row_bits-1:0]              num_rows,
  input  logic [array_size-1:0]            fifo_empty,
  output logic [array_size-1:0]            fifo_r_en,
  input  logic [data_size*array_size-1:0]  fifo_data,
  output logic [data_size-1:0]             out_data,
  output logic [addr_width-1:0]            out_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [row_bits-1:0]     r_rows;
  logic [row_bits-1:0]     r_row;
  logic [col_bits-1:0]     r_col;
  logic [addr_width-1:0]   r_addr;
  logic [data_size-1:0]    r_data;

  logic [array_size-1:0]   w_r_en;
  logic [data_size-1:0]    w_sel;
  logic                    w_empty;
  logic                    w_last_col;
  logic                    w_last;
  logic                    w_hs;

  // Column mux for the current column's data, empty flag and read enable.
  always_comb begin
    w_sel   = '0;
    w_empty = 1'b1;
    w_r_en  = '0;
    for (int unsigned c = 0; c < array_size; c++) begin
      if (r_col == col_bits'(c)) begin
        w_sel     = fifo_data[c*data_size +: data_size];
        w_empty   = fifo_empty[c];
        w_r_en[c] = (r_state == S_READ);
      end
    end
  end

  assign w_last_col = (r_col == col_bits'(array_size - 1));
  assign w_last     = w_last_col && (r_row == r_rows - row_bits'(1));
  assign w_hs       = (r_state == S_SEND) && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (num_rows == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_empty) begin
          w_next = S_READ;
        end
      end
      S_READ: w_next = S_CAPT;
      S_CAPT: w_next = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          w_next = w_last ? S_DONE : S_WAIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rows  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows <= num_rows;
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
          end
        end
        S_CAPT: r_data <= w_sel;
        S_SEND: begin
          if (out_ready) begin
            r_addr <= r_addr + addr_width'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + row_bits'(1);
            end else begin
              r_col <= r_col + col_bits'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_r_en = w_r_en;
  assign out_data  = r_data;
  assign out_addr  = r_addr;
  assign out_valid = (r_state == S_SEND);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fifo_array_drain.sv
// Bench for fifo_array_drain: behavioural FIFO array plus a per-column queue scoreboard.
module tb_fifo_array_drain;

  localparam int NC = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    num_rows;
  logic [NC-1:0] fifo_empty;
  logic [NC-1:0] fifo_r_en;
  logic [71:0]   fifo_data;
  logic [7:0]    out_data;
  logic [15:0]   out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_array_drain #(
    .data_size (8),
    .array_size(NC),
    .col_bits  (4),
    .row_bits  (8),
    .addr_width(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .fifo_data (fifo_data),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // FIFO array with one-cycle read latency
  logic [7:0]  mem [NC][256];
  int unsigned wr_ptr [NC] = '{default: 0};
  int unsigned rd_ptr [NC] = '{default: 0};
  logic [7:0]  dout   [NC] = '{default: 8'h00};

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      fifo_empty[c]       = (wr_ptr[c] == rd_ptr[c]);
      fifo_data[c*8 +: 8] = dout[c];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (fifo_r_en[c] && (wr_ptr[c] != rd_ptr[c])) begin
        dout[c]   <= mem[c][rd_ptr[c][7:0]];
        rd_ptr[c] <= rd_ptr[c] + 1;
      end
    end
  end

  // Scoreboard: the word at address k comes from column k mod NC, in FIFO order.
  logic [7:0] mq [NC][$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr;
  int words_seen;
  int ren_cnt [NC];
  int ready_mode = 0;
  int tick_no = 0;

  typedef struct {
    int rows;
    int mode;
    int stall_col;
    int exp_cycles;
    int exp_words;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input logic [7:0] v);
    mem[c][wr_ptr[c][7:0]] = v;
    wr_ptr[c] = wr_ptr[c] + 1;
    mq[c].push_back(v);
  endtask

  task automatic set_ready();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((tick_no / 3) % 2) == 0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    logic       stall_v;
    logic [7:0] pd;
    logic [15:0] pa;
    int         c;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      c = exp_addr % NC;
      chk("sb_avail", 32'(mq[c].size() > 0), 1);
      if (mq[c].size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq[c].pop_front()));
        chk("out_addr", 32'(out_addr), 32'(exp_addr[15:0]));
      end
      exp_addr++;
      words_seen++;
    end
    stall_v = (out_valid === 1'b1) && (out_ready === 1'b0);
    pd = out_data;
    pa = out_addr;
    @(posedge clk);
    #1;
    tick_no++;
    if (stall_v) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(pd));
      chk("hold_addr", 32'(out_addr), 32'(pa));
    end
    if (fifo_r_en != '0) begin
      chk("r_en_onehot", 32'($onehot(fifo_r_en)), 1);
      for (int k = 0; k < NC; k++) begin
        if (fifo_r_en[k]) begin
          ren_cnt[k]++;
          chk("r_en_nonempty", 32'(fifo_empty[k]), 0);
        end
      end
    end
    set_ready();
  endtask

  task automatic run_drain(input vec_t v);
    int   t;
    logic stall_bad;
    words_seen = 0;
    stall_bad  = 1'b0;
    for (int c = 0; c < NC; c++) ren_cnt[c] = 0;
    for (int r = 0; r < v.rows; r++)
      for (int c = 0; c < NC; c++)
        if (c != v.stall_col) push(c, 8'($urandom));
    ready_mode = v.mode;
    set_ready();
    start    = 1'b1;
    num_rows = 8'(v.rows);
    exp_addr = 0;
    tick();
    start    = 1'b0;
    num_rows = 8'($urandom);
    t = 1;
    chk("busy_after_start", 32'(busy), 1);
    while (done !== 1'b1 && t < 3000) begin
      if (v.stall_col >= 0 && t >= 17 && t <= 37) begin
        if (fifo_r_en != '0 || out_valid !== 1'b0) stall_bad = 1'b1;
        if (t == 37)
          for (int r = 0; r < v.rows; r++) push(v.stall_col, 8'($urandom));
      end
      tick();
      t++;
    end
    chk("done_seen", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 1);
    if (v.exp_cycles >= 0) chk("done_cycle", 32'(t), 32'(v.exp_cycles));
    chk("word_count", 32'(words_seen), 32'(v.exp_words));
    if (v.stall_col >= 0) chk("stall_quiet", 32'(stall_bad), 0);
    for (int c = 0; c < NC; c++) chk("r_en_pulses", 32'(ren_cnt[c]), 32'(v.rows));
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    vec_t tbl [5];
    vec_t rv;
    int   t;
    tbl[0] = '{rows: 0, mode: 0, stall_col: -1, exp_cycles: 1,   exp_words: 0};
    tbl[1] = '{rows: 2, mode: 0, stall_col: -1, exp_cycles: 73,  exp_words: 18};
    tbl[2] = '{rows: 1, mode: 0, stall_col: 4,  exp_cycles: 57,  exp_words: 9};
    tbl[3] = '{rows: 2, mode: 1, stall_col: -1, exp_cycles: -1,  exp_words: 18};
    tbl[4] = '{rows: 3, mode: 0, stall_col: -1, exp_cycles: 109, exp_words: 27};

    rst_n = 1'b0; start = 1'b0; num_rows = '0; out_ready = 1'b0;
    exp_addr = 0; words_seen = 0;
    tick();
    tick();
    chk("rst_r_en", 32'(fifo_r_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run_drain(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      rv.rows = int'($urandom_range(1, 3));
      rv.mode = 2;
      rv.stall_col = -1;
      rv.exp_cycles = -1;
      rv.exp_words = rv.rows * NC;
      run_drain(rv);
    end

    // Reset after five words of a two-row drain, then a fresh one-row drain.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) push(c, 8'($urandom));
    ready_mode = 0; set_ready();
    words_seen = 0; exp_addr = 0;
    start = 1'b1; num_rows = 8'd2;
    tick();
    start = 1'b0;
    t = 0;
    while (words_seen < 5 && t < 200) begin tick(); t++; end
    chk("five_words", 32'(words_seen), 5);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_r_en", 32'(fifo_r_en), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_addr", 32'(out_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy | done), 0);
    rv = '{rows: 1, mode: 0, stall_col: -1, exp_cycles: 37, exp_words: 9};
    run_drain(rv);

    // start held high through a drain and its done cycle.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) push(c, 8'($urandom));
    ready_mode = 0; set_ready();
    words_seen = 0; exp_addr = 0;
    start = 1'b1; num_rows = 8'd1;
    tick();
    t = 1;
    while (done !== 1'b1 && t < 500) begin tick(); t++; end
    chk("held_done_cycle", 32'(t), 37);
    chk("held_words", 32'(words_seen), 9);
    tick();
    chk("held_idle_busy", 32'(busy), 0);
    chk("held_idle_done", 32'(done), 0);
    words_seen = 0; exp_addr = 0;
    tick();
    chk("held_restart_busy", 32'(busy), 1);
    start = 1'b0;
    t = 1;
    while (done !== 1'b1 && t < 500) begin tick(); t++; end
    chk("restart_done_cycle", 32'(t), 37);
    chk("restart_words", 32'(words_seen), 9);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
